// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM state encodings,
// start/ready handshake levels and the common register-bus constants.
// Imported by div_unit; holds no logic.
package div_unit_pkg;

  // Register bus widths and the all-zero word.
  localparam int          RegBusW      = 32;
  localparam int          DoubleRegBusW = 64;
  localparam logic [RegBusW-1:0] ZeroWord = '0;

  // Divider FSM state encodings.
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  // Handshake levels.
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV / DIVU) for the EX stage.
// Latency: WIDTH+2 edges from the start-sampling edge (2 for divide-by-zero).
// Backpressure: result_o/ready_o are held in END while start_i stays high.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   signed_div_i    1 = signed DIV, 0 = DIVU
//   opdata1_i/2_i   dividend / divisor, sampled only while FREE
//   start_i         request, held by EX until ready_o
//   annul_i         abort an in-flight division (flush / exception)
//   result_o        {remainder, quotient}: HI = upper half, LO = lower half
//   ready_o         result_o valid
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  logic [1:0]           state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  // Working register: upper half is the partial remainder, lower half holds
  // the not-yet-consumed dividend bits with quotient bits shifting in at bit 0.
  logic [2*WIDTH-1:0]   dq_q,      dq_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q,  neg_rem_d;
  logic [2*WIDTH-1:0]   result_q,  result_d;
  logic                 ready_q,   ready_d;

  logic                 op1_neg, op2_neg;
  logic [WIDTH-1:0]     op1_mag, op2_mag;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;

  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign op1_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_mag = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // The shifted partial remainder's upper WIDTH+1 bits are dq_q[2W-1:W-1];
  // one WIDTH+1-bit subtract tells whether the divisor fits (MSB clear).
  assign trial = dq_q[2*WIDTH-1:WIDTH-1] - {1'b0, divisor_q};

  assign quot_raw = dq_q[WIDTH-1:0];
  assign rem_raw  = dq_q[2*WIDTH-1:WIDTH];
  assign quot_fix = neg_quot_q ? (~quot_raw + 1'b1) : quot_raw;
  assign rem_fix  = neg_rem_q  ? (~rem_raw  + 1'b1) : rem_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dq_d       = dq_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          // Quotient sign differs when operand signs differ; the remainder
          // follows the dividend's sign.
          neg_quot_d = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            dq_d      = {{WIDTH{1'b0}}, op1_mag};
            divisor_d = op2_mag;
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          if (!trial[WIDTH]) begin
            // Remainder after a successful subtract is below the divisor, so
            // it fits back into WIDTH bits.
            dq_d = {trial[WIDTH-1:0], dq_q[WIDTH-2:0], 1'b1};
          end else begin
            dq_d = {dq_q[2*WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
        end
      end

      default: begin // DivEnd: annul_i deliberately ignored here
        if (start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dq_q       <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dq_q       <= dq_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  // Stimulus driver: raises start, scrambles operands after the sampling
  // edge, and counts rising edges until ready_o (bounded). Leaves start high.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output logic [63:0] res);
    signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        op1 = 32'h5A5A_1234; op2 = 32'h0000_0003; signed_div = ~sgn;
      end
    end while (!ready && edges < 100);
    res = result;
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_checks++;
    if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic();
    int e; logic [63:0] r;
    run_op(1'b0, 32'd100, 32'd7, e, r);
    n_checks++;
    if (e !== 34) begin n_fail++; $display("FAIL divu_100_7_latency got=%0d exp=34", e); end
    n_checks++;
    if (r !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL divu_100_7_result got=%h exp=00000002_0000000e", r); end
    // start still high: result must be held
    @(posedge clk); #1;
    n_checks++;
    if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
      n_fail++; $display("FAIL end_hold got ready=%b res=%h exp ready=1 res=00000002_0000000e", ready, result);
    end
    drop_start();
    n_checks++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      n_fail++; $display("FAIL end_release got ready=%b res=%h exp ready=0 res=0", ready, result);
    end
  endtask

  task automatic test_signed();
    int e; logic [63:0] r;
    logic        sg  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] a   [4] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] b   [4] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000002};
    logic [63:0] exp [4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                             64'hFFFFFFFF_00000003, 64'h00000001_7FFFFFFC};
    for (int i = 0; i < 4; i++) begin
      run_op(sg[i], a[i], b[i], e, r);
      n_checks++;
      if (e !== 34) begin n_fail++; $display("FAIL signed_%0d_latency got=%0d exp=34", i, e); end
      n_checks++;
      if (r !== exp[i]) begin n_fail++; $display("FAIL signed_%0d_result got=%h exp=%h", i, r, exp[i]); end
      drop_start();
    end
  endtask

  task automatic test_by_zero();
    int e; logic [63:0] r;
    run_op(1'b0, 32'd5, 32'd0, e, r);
    n_checks++;
    if (e !== 2) begin n_fail++; $display("FAIL byzero_latency got=%0d exp=2", e); end
    n_checks++;
    if (r !== 64'h0 || ready !== 1'b1) begin n_fail++; $display("FAIL byzero_result got=%h rdy=%b exp=0 rdy=1", r, ready); end
    drop_start();
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, e, r);
    n_checks++;
    if (r !== 64'h00000000_FFFFFFFF || e !== 34) begin
      n_fail++; $display("FAIL divu_max_by_1 got=%h edges=%0d exp=00000000_ffffffff edges=34", r, e);
    end
    drop_start();
  endtask

  task automatic test_overflow();
    int e; logic [63:0] r;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, e, r);
    n_checks++;
    if (r !== 64'h00000000_80000000 || e !== 34) begin
      n_fail++; $display("FAIL div_overflow got=%h edges=%0d exp=00000000_80000000 edges=34", r, e);
    end
    drop_start();
  endtask

  task automatic test_annul();
    int e; logic [63:0] r; int seen;
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
    repeat (11) begin @(posedge clk); #1; end   // counter now at 10
    annul = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      n_fail++; $display("FAIL annul_on got ready=%b res=%h exp ready=0 res=0", ready, result);
    end
    annul = 1'b0; start = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL annul_no_ready got=%0d ready cycles exp=0", seen); end
    run_op(1'b0, 32'd9, 32'd3, e, r);
    n_checks++;
    if (r !== 64'h00000000_00000003 || e !== 34) begin
      n_fail++; $display("FAIL after_annul_9_3 got=%h edges=%0d exp=00000000_00000003 edges=34", r, e);
    end
    drop_start();
    // annul while in the divide-by-zero state
    signed_div = 1'b0; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    seen = 0;
    repeat (5) begin if (ready) seen++; @(posedge clk); #1; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL annul_byzero got=%0d ready cycles exp=0", seen); end
  endtask

  task automatic test_async_reset();
    int e; logic [63:0] r;
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      n_fail++; $display("FAIL async_rst_on got ready=%b res=%h exp ready=0 res=0", ready, result);
    end
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 32'd100, 32'd7, e, r);
    n_checks++;
    if (r !== 64'h00000002_0000000E || e !== 34) begin
      n_fail++; $display("FAIL after_rst_100_7 got=%h edges=%0d exp=00000002_0000000e edges=34", r, e);
    end
    // reset while a result is being held must clear outputs without a clock
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      n_fail++; $display("FAIL async_rst_end got ready=%b res=%h exp ready=0 res=0", ready, result);
    end
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_by_zero();
    test_overflow();
    test_annul();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
